store_buffer: RTL and testbench
===============================

# store_buffer

Store-side counterpart to the immediate/load extender: instead of widening narrow values to 32 bits, it narrows a 32-bit register value to the byte, halfword or word selected by a store instruction. It places the narrowed value on the correct byte lanes with a byte-enable mask and detects misaligned stores. Accepted stores are queued in a small FIFO and drained to data memory one per handshake. It sits between the MEM-stage store path and the DM write port.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  store request present
- req_ready  out  1  buffer can accept (registered, = !full)
- req_addr  in  32  byte address
- req_data  in  32  register value (rt)
- req_size  in  2  `ST_BYTE=2'b00, `ST_HALF=2'b01, `ST_WORD=2'b10, 2'b11 reserved
- mem_valid  out  1  head entry valid (= count!=0)
- mem_ready  in  1  memory accepts head entry
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  lane-replicated data
- mem_be  out  4  byte enables, bit i = byte lane i
- err_valid  out  1  one-cycle pulse: rejected store
- err_addr  out  32  address of last rejected store
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Narrowing, on accept (req_valid && req_ready):
  - byte: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{data[15:0]}}, be=addr[1]?4'b1100:4'b0011; error if addr[0]=1
  - word: wdata=data, be=4'b1111; error if addr[1:0]!=0
  - size 2'b11: error
- Stored mem_addr={req_addr[31:2],2'b00}.
- Erroring requests complete the handshake but are NOT enqueued. err_valid=1 on the next cycle; err_addr is set to req_addr and holds until the next error.
- FIFO: write pointer advances on a valid (non-error) accept; read pointer advances on mem_valid && mem_ready. Both wrap modulo DEPTH.
- mem_addr/mem_wdata/mem_be show the head entry when count!=0 and are driven 0 when empty.
- No FSM. Occupancy is tracked by count:
  - push only: +1
  - pop only: −1
  - push+pop in the same cycle: unchanged

## Timing
- Reset, asynchronous: count=0, pointers=0, mem_valid=0, mem_addr/mem_wdata/mem_be=0, err_valid=0, err_addr=0, req_ready=1.
- Reset mid-operation discards all queued entries. No partial writes are reissued.
- Latency: a store accepted in cycle N into an empty buffer appears on mem_* in cycle N+1.
- req_ready depends only on registered count. There is no combinational path from mem_ready. When full, req_ready=0 even if a pop occurs that cycle; it rises the cycle after the pop.
- mem_* stay stable while mem_valid && !mem_ready.
- Error pulse: exactly one cycle per erroring accept. Back-to-back errors give consecutive pulses, each with its own err_addr.
- Simultaneous push and pop with count=1: the head advances to the new entry, count stays 1.

## Structure
- The size codes `ST_BYTE/`ST_HALF/`ST_WORD belong in the shared macro.v header, alongside the EXT op codes.
- Sub-module store_narrow is combinational: (addr, data, size) -> (wdata, be, misaligned).
- store_buffer instantiates store_narrow and holds the FIFO storage, pointers and the error register.

## Test plan
- Reset, then sb addr=0x1003 data=0x123456AB -> next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0xABABABAB, mem_be=4'b1000.
- sh addr=0x2002 data=0xDEADBEEF, then sh addr=0x2001 -> first: wdata=0xBEEFBEEF, be=4'b1100. Second: not queued, err_valid pulse, err_addr=0x2001.
- mem_ready=0, push DEPTH sw stores -> count=DEPTH, req_ready=0. Assert mem_ready for one cycle with req_valid held -> req_ready=1 only the following cycle; FIFO order preserved.
- count=1 with push and pop in the same cycle -> count stays 1, new entry at head next cycle.
- Stream 3·DEPTH words with mem_ready toggling -> every entry delivered once, in order, across pointer wrap.
- Reset asserted asynchronously with 3 entries queued -> mem_valid=0, count=0 immediately; no stale entry appears after release.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: store size codes and the queued
// entry layout used between the narrowing logic and the FIFO.
package store_buffer_pkg;

    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_narrow.sv
// Combinational store narrowing: replicates the register value across
// byte lanes, builds the byte-enable mask and flags misaligned stores.
module store_narrow
    import store_buffer_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    always_comb begin
        wdata      = '0;
        be         = '0;
        misaligned = 1'b0;
        case (size)
            ST_BYTE: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr;
            end
            ST_HALF: begin
                wdata      = {2{data[15:0]}};
                be         = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            ST_WORD: begin
                wdata      = data;
                be         = 4'b1111;
                misaligned = addr != 2'b00;
            end
            // Reserved size code is always rejected
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: narrows accepted stores onto byte lanes, queues them in a
// small FIFO and drains one entry per memory handshake.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_data,
    input  logic [1:0]               req_size,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic                     err_valid,
    output logic [31:0]              err_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    sb_entry_t       fifo_q [DEPTH];
    sb_entry_t       head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [31:0]     n_wdata;
    logic [3:0]      n_be;
    logic            n_mis;
    logic            accept;
    logic            push;
    logic            pop;

    store_narrow u_narrow (
        .addr       (req_addr[1:0]),
        .data       (req_data),
        .size       (req_size),
        .wdata      (n_wdata),
        .be         (n_be),
        .misaligned (n_mis)
    );

    // Ready comes only from registered occupancy, never from mem_ready
    assign req_ready = count != FULL;
    assign mem_valid = count != '0;
    assign accept    = req_valid && req_ready;
    assign push      = accept && !n_mis;
    assign pop       = mem_valid && mem_ready;
    assign head      = fifo_q[rd_ptr];

    assign mem_addr  = mem_valid ? head.addr  : '0;
    assign mem_wdata = mem_valid ? head.wdata : '0;
    assign mem_be    = mem_valid ? head.be    : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{
                addr:  {req_addr[31:2], 2'b00},
                wdata: n_wdata,
                be:    n_be
            };
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else begin
            err_valid <= accept && n_mis;
            if (accept && n_mis) err_addr <= req_addr;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus records expected entries and
// errors; an independent monitor compares them against the DUT outputs.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [$clog2(DEPTH):0] count;

    exp_t        exp_q[$];
    logic [31:0] err_q[$];
    logic [31:0] last_err = '0;
    int          vectors = 0;
    int          miscompares = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: store touches n bytes starting at lane addr%4; each lane
    // carries data byte (lane % n). Returns 1 when the store is rejected.
    function automatic bit model(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] s, output exp_t e);
        int n;
        int lane;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
        e.addr  = a - (a % 4);
        e.wdata = '0;
        e.be    = '0;
        if (n == 0 || (a % n) != 0) return 1'b1;
        lane = int'(a % 4);
        for (int i = 0; i < 4; i++) begin
            e.wdata[i*8 +: 8] = d[(i % n)*8 +: 8];
            if (i >= lane && i < lane + n) e.be[i] = 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock of stimulus: drive after posedge, record the accept after negedge
    task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit mr);
        exp_t e;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        mem_ready = mr;
        @(negedge clk);
        #1;
        if (req_valid && req_ready) begin
            if (model(a, d, s, e)) err_q.push_back(a);
            else exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
            chk("err_valid", 32'(err_valid), 32'(err_q.size() != 0));
            if (err_valid && err_q.size() != 0) last_err = err_q.pop_front();
            chk("err_addr", err_addr, last_err);
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_head", 32'(mem_valid), 32'd0);
                end else begin
                    chk("mem_addr", mem_addr, exp_q[0].addr);
                    chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                    chk("mem_be", 32'(mem_be), 32'(exp_q[0].be));
                    if (mem_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_outputs", mem_addr | mem_wdata | 32'(mem_be), 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_err", 32'(err_valid) | err_addr, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Byte store on lane 3
        cyc(1, 32'h0000_1003, 32'h1234_56AB, 2'b00, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_be", 32'(mem_be), 32'h8);
        cyc(0, 0, 0, 0, 1);

        // Aligned halfword, then misaligned halfword
        cyc(1, 32'h0000_2002, 32'hDEAD_BEEF, 2'b01, 0);
        cyc(1, 32'h0000_2001, 32'hDEAD_BEEF, 2'b01, 0);
        cyc(0, 0, 0, 0, 1);
        chk("sh_err_addr", err_addr, 32'h0000_2001);
        cyc(0, 0, 0, 0, 0);

        // Back-to-back errors including reserved size
        cyc(1, 32'h0000_3002, 32'h1, 2'b10, 0);
        cyc(1, 32'h0000_3004, 32'h2, 2'b11, 0);
        cyc(0, 0, 0, 0, 0);

        // Fill, then one pop with request held
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 32'h4000 + 32'(i*4), 32'hA000_0000 + 32'(i), 2'b10, 0);
        chk("full_ready", 32'(req_ready), 32'd0);
        cyc(1, 32'h5000, 32'h5555_5555, 2'b10, 1);
        cyc(1, 32'h5000, 32'h5555_5555, 2'b10, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 1);

        // Push and pop together with one entry queued
        cyc(1, 32'h6000, 32'h6666_6666, 2'b10, 0);
        cyc(1, 32'h6004, 32'h7777_7777, 2'b10, 1);
        chk("pp_count", 32'(count), 32'd1);
        cyc(0, 0, 0, 0, 1);

        // Stream words across pointer wrap with toggling mem_ready
        for (int i = 0; i < 3 * DEPTH; i++)
            cyc(1, 32'h8000 + 32'(i*4), $urandom, 2'b10, i[0]);
        for (int i = 0; i < 3 * DEPTH; i++) cyc(0, 0, 0, 0, $urandom_range(0, 1) == 1);
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 1);

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            s = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
            cyc($urandom_range(0, 3) != 0, a, $urandom, s,
                $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 1);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++)
            cyc(1, 32'h9000 + 32'(i*4), 32'h9999_0000 + 32'(i), 2'b10, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_mem_valid", 32'(mem_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        exp_q.delete();
        err_q.delete();
        last_err = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        cyc(1, 32'hA001, 32'h0000_00C3, 2'b00, 0);
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 1);

        chk("drained", 32'(exp_q.size()), 32'd0);
        chk("errs_seen", 32'(err_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
